// File: rtl/pixel_stream_gen_pkg.sv
// Shared types for the gradient pixel stream generator: colour struct, FSM states,
// frame counter width and the per-pixel gradient colour function.
package pixel_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } psg_state_e;

    function automatic rgb_t gradient(input logic [7:0] x8, input logic [7:0] y8);
        rgb_t c;
        c.r = x8;
        c.g = y8;
        c.b = x8 ^ y8;
        return c;
    endfunction

endpackage

// File: rtl/pixel_stream_gen_if.sv
// Valid/ready pixel stream carrying one RGB beat with its coordinates and
// start-of-frame / end-of-line flags.
interface pixel_stream_gen_if
    import pixel_pkg::*;
#(
    parameter int COORD_W = 10
);
    logic               out_valid;
    logic               out_ready;
    rgb_t               out_rgb;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               out_sof;
    logic               out_eol;

    modport master (
        output out_valid, out_rgb, out_x, out_y, out_sof, out_eol,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_rgb, out_x, out_y, out_sof, out_eol,
        output out_ready
    );
endinterface

// File: rtl/pixel_stream_gen_counter.sv
// Raster x/y counter for an H_RES x V_RES frame; advances one pixel per adv pulse
// and reports first pixel, end of line and end of frame for the current position.
module pixel_coord_counter #(
    parameter int H_RES   = 256,
    parameter int V_RES   = 256,
    parameter int COORD_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_adv,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_first,
    output logic               o_eol,
    output logic               o_last
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (r_x == X_MAX) begin
                r_x <= '0;
                r_y <= (r_y == Y_MAX) ? '0 : r_y + COORD_W'(1);
            end else begin
                r_x <= r_x + COORD_W'(1);
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_first = (r_x == '0) && (r_y == '0);
    assign o_eol   = (r_x == X_MAX);
    assign o_last  = (r_x == X_MAX) && (r_y == Y_MAX);
endmodule

// File: rtl/pixel_stream_gen.sv
// Gradient raster source: streams one registered RGB beat per accepted cycle for a full frame.
// Optional PSG_FRAME_CNT_EN adds a 16-bit completed-frame counter output o_frame_cnt.
module pixel_stream_gen
    import pixel_pkg::*;
#(
    parameter int H_RES   = 256,
    parameter int V_RES   = 256,
    parameter int COORD_W = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    pixel_stream_gen_if.master     m_out,
    output logic                   o_busy,
    output logic                   o_frame_done
`ifdef PSG_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
`endif
);
    psg_state_e r_state;
    psg_state_e w_next;

    logic               w_load;
    logic               w_accept;
    logic               w_clr;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_first;
    logic               w_eol;
    logic               w_last;

    logic               r_valid;
    rgb_t               r_rgb;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_sof;
    logic               r_eol;
    logic               r_frame_done;

    assign w_load   = (r_state == RUN) && (!r_valid || m_out.out_ready);
    assign w_accept = r_valid && m_out.out_ready;
    assign w_clr    = (r_state == IDLE) && i_start;

    pixel_coord_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .COORD_W(COORD_W)
    ) u_counter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_adv  (w_load),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_first(w_first),
        .o_eol  (w_eol),
        .o_last (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // DRAIN waits for the final beat, already loaded, to be taken downstream.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start)          w_next = RUN;
            RUN:     if (w_load && w_last) w_next = DRAIN;
            DRAIN:   if (w_accept)         w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rgb   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_rgb   <= gradient(w_x[7:0], w_y[7:0]);
            r_x     <= w_x;
            r_y     <= w_y;
            r_sof   <= w_first;
            r_eol   <= w_eol;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_frame_done <= 1'b0;
        else       r_frame_done <= (r_state == DRAIN) && w_accept;
    end

`ifdef PSG_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)                            r_frame_cnt <= '0;
        else if ((r_state == DRAIN) && w_accept) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

    assign m_out.out_valid = r_valid;
    assign m_out.out_rgb   = r_rgb;
    assign m_out.out_x     = r_x;
    assign m_out.out_y     = r_y;
    assign m_out.out_sof   = r_sof;
    assign m_out.out_eol   = r_eol;
    assign o_busy          = (r_state != IDLE);
    assign o_frame_done    = r_frame_done;
endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen: a 4x2 instance driven from a vector table plus
// hand sequences, and a 300x1 instance for colour wrap. Set PSG_FRAME_CNT_EN for frame_cnt.
module tb_pixel_stream_gen;

    typedef struct {
        logic        rst;
        logic        start;
        logic        ready;
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        busy;
        logic        done;
        bit          chk;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA   = 1'b1;
    logic startA = 1'b0;
    logic busyA;
    logic doneA;
    logic rstB   = 1'b1;
    logic startB = 1'b0;
    logic busyB;
    logic doneB;
`ifdef PSG_FRAME_CNT_EN
    logic [15:0] cntA;
    logic [15:0] cntB;
`endif

    pixel_stream_gen_if #(.COORD_W(10)) ifA ();
    pixel_stream_gen_if #(.COORD_W(10)) ifB ();

    pixel_stream_gen #(.H_RES(4), .V_RES(2), .COORD_W(10)) dutA (
        .i_clk       (clk),
        .i_rst       (rstA),
        .i_start     (startA),
        .m_out       (ifA),
        .o_busy      (busyA),
        .o_frame_done(doneA)
`ifdef PSG_FRAME_CNT_EN
        ,
        .o_frame_cnt (cntA)
`endif
    );

    pixel_stream_gen #(.H_RES(300), .V_RES(1), .COORD_W(10)) dutB (
        .i_clk       (clk),
        .i_rst       (rstB),
        .i_start     (startB),
        .m_out       (ifB),
        .o_busy      (busyB),
        .o_frame_done(doneB)
`ifdef PSG_FRAME_CNT_EN
        ,
        .o_frame_cnt (cntB)
`endif
    );

    int   nVec  = 0;
    int   nMiss = 0;
    vec_t vecs[$];

    function automatic vec_t V(input logic rst, start, ready, valid, input int x, y,
                               input logic [23:0] rgb, input logic sof, eol, busy, done,
                               input bit chk);
        vec_t v;
        v.rst = rst; v.start = start; v.ready = ready; v.valid = valid;
        v.x = 10'(x); v.y = 10'(y); v.rgb = rgb; v.sof = sof; v.eol = eol;
        v.busy = busy; v.done = done; v.chk = chk;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        nVec++;
        if (got !== want) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive one table row, clock it in, and compare DUT A against the row's expectations.
    task automatic applyStimulus(input vec_t v, input int idx);
        bit bad;
        rstA = v.rst;
        startA = v.start;
        ifA.out_ready = v.ready;
        step();
        bad = (ifA.out_valid !== v.valid) || (busyA !== v.busy) || (doneA !== v.done);
        if (v.chk)
            bad = bad || (ifA.out_x !== v.x) || (ifA.out_y !== v.y) || (ifA.out_rgb !== v.rgb)
                      || (ifA.out_sof !== v.sof) || (ifA.out_eol !== v.eol);
        nVec++;
        if (bad) begin
            nMiss++;
            $display("[TB] FAIL vec[%0d]: got v=%b x=%0d y=%0d rgb=%h sof=%b eol=%b busy=%b done=%b, want v=%b x=%0d y=%0d rgb=%h sof=%b eol=%b busy=%b done=%b",
                     idx, ifA.out_valid, ifA.out_x, ifA.out_y, ifA.out_rgb, ifA.out_sof, ifA.out_eol,
                     busyA, doneA, v.valid, v.x, v.y, v.rgb, v.sof, v.eol, v.busy, v.done);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  beats;
        int  seqErr;
        int  doneCnt;
        int  eolCnt;
        int  eolX;
        bit  found;
        bit  sawDone;
        bit  saw257;

        ifA.out_ready = 1'b1;
        ifB.out_ready = 1'b1;

        // Reset, free-flow frame, then a frame with a 3-cycle stall on beat (2,0).
        vecs.push_back(V(1,0,1, 0,0,0,24'h000000,0,0,0,0,1));
        vecs.push_back(V(1,0,1, 0,0,0,24'h000000,0,0,0,0,1));
        vecs.push_back(V(0,1,1, 0,0,0,24'h000000,0,0,1,0,0));
        vecs.push_back(V(0,0,1, 1,0,0,24'h000000,1,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,1,0,24'h010001,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,2,0,24'h020002,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,3,0,24'h030003,0,1,1,0,1));
        vecs.push_back(V(0,0,1, 1,0,1,24'h000101,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,1,1,24'h010100,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,2,1,24'h020103,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,3,1,24'h030102,0,1,1,0,1));
        vecs.push_back(V(0,0,1, 0,0,0,24'h000000,0,0,0,1,0));
        vecs.push_back(V(0,0,1, 0,0,0,24'h000000,0,0,0,0,0));
        vecs.push_back(V(0,1,1, 0,0,0,24'h000000,0,0,1,0,0));
        vecs.push_back(V(0,0,1, 1,0,0,24'h000000,1,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,1,0,24'h010001,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,2,0,24'h020002,0,0,1,0,1));
        vecs.push_back(V(0,0,0, 1,2,0,24'h020002,0,0,1,0,1));
        vecs.push_back(V(0,0,0, 1,2,0,24'h020002,0,0,1,0,1));
        vecs.push_back(V(0,0,0, 1,2,0,24'h020002,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,3,0,24'h030003,0,1,1,0,1));
        vecs.push_back(V(0,0,1, 1,0,1,24'h000101,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,1,1,24'h010100,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,2,1,24'h020103,0,0,1,0,1));
        vecs.push_back(V(0,0,1, 1,3,1,24'h030102,0,1,1,0,1));
        vecs.push_back(V(0,0,1, 0,0,0,24'h000000,0,0,0,1,0));
        vecs.push_back(V(0,0,1, 0,0,0,24'h000000,0,0,0,0,0));

        rstB = 1'b0;
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        checkOutput("resetB_valid", 32'(ifB.out_valid), 32'd0);
        checkOutput("resetB_busy", 32'(busyB), 32'd0);

        // Start pulsed mid-frame must not restart or add beats.
        $display("[TB] start-ignored sequence");
        beats = 0; seqErr = 0; doneCnt = 0;
        ifA.out_ready = 1'b1;
        startA = 1'b1;
        step();
        for (int c = 0; c < 40; c++) begin
            startA = (c == 4 || c == 5);
            if (ifA.out_valid && ifA.out_ready) begin
                if (ifA.out_x != 10'(beats % 4) || ifA.out_y != 10'(beats / 4)) seqErr++;
                beats++;
            end
            step();
            if (doneA) doneCnt++;
        end
        startA = 1'b0;
        checkOutput("ignore_beats", 32'(beats), 32'd8);
        checkOutput("ignore_order", 32'(seqErr), 32'd0);
        checkOutput("ignore_done", 32'(doneCnt), 32'd1);
        checkOutput("ignore_busy", 32'(busyA), 32'd0);

        // Reset right after beat (1,1) is presented.
        $display("[TB] reset mid-frame sequence");
        found = 1'b0;
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (ifA.out_valid && ifA.out_x == 10'd1 && ifA.out_y == 10'd1) found = 1'b1;
        end
        checkOutput("rstmid_found11", 32'(found), 32'd1);
        rstA = 1'b1;
        step();
        checkOutput("rstmid_valid", 32'(ifA.out_valid), 32'd0);
        checkOutput("rstmid_busy", 32'(busyA), 32'd0);
        checkOutput("rstmid_done", 32'(doneA), 32'd0);
        rstA = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (doneA) sawDone = 1'b1;
        end
        checkOutput("rstmid_nodone", 32'(sawDone), 32'd0);
        checkOutput("rstmid_idle", 32'({ifA.out_valid, busyA}), 32'd0);
        startA = 1'b1;
        step();
        startA = 1'b0;
        step();
        checkOutput("restart_beat", 32'({ifA.out_valid, ifA.out_sof, ifA.out_x, ifA.out_y}), 32'({1'b1, 1'b1, 10'd0, 10'd0}));
        checkOutput("restart_rgb", 32'(ifA.out_rgb), 32'h000000);
        for (int c = 0; c < 30 && busyA; c++) step();
        step();

`ifdef PSG_FRAME_CNT_EN
        // Three back-to-back frames with start held high.
        $display("[TB] frame counter sequence");
        rstA = 1'b1;
        step();
        rstA = 1'b0;
        checkOutput("fcnt_reset", 32'(cntA), 32'd0);
        doneCnt = 0;
        startA = 1'b1;
        for (int c = 0; c < 100 && doneCnt < 3; c++) begin
            step();
            if (doneA) begin
                doneCnt++;
                checkOutput($sformatf("fcnt_frame%0d", doneCnt), 32'(cntA), 32'(doneCnt));
            end
        end
        startA = 1'b0;
        checkOutput("fcnt_frames", 32'(doneCnt), 32'd3);
        for (int c = 0; c < 30 && busyA; c++) step();
`endif

        // Colour wrap on the 300-pixel line.
        $display("[TB] colour wrap sequence");
        beats = 0; eolCnt = 0; eolX = -1; saw257 = 1'b0; sawDone = 1'b0;
        ifB.out_ready = 1'b1;
        startB = 1'b1;
        step();
        startB = 1'b0;
        for (int c = 0; c < 400 && !sawDone; c++) begin
            if (ifB.out_valid && ifB.out_ready) begin
                beats++;
                if (ifB.out_x == 10'd257) begin
                    saw257 = 1'b1;
                    checkOutput("wrap_rgb257", 32'(ifB.out_rgb), 32'h010001);
                end
                if (ifB.out_eol) begin
                    eolCnt++;
                    eolX = int'(ifB.out_x);
                end
            end
            step();
            if (doneB) sawDone = 1'b1;
        end
        checkOutput("wrap_saw257", 32'(saw257), 32'd1);
        checkOutput("wrap_beats", 32'(beats), 32'd300);
        checkOutput("wrap_eolcnt", 32'(eolCnt), 32'd1);
        checkOutput("wrap_eolx", 32'(eolX), 32'd299);
        checkOutput("wrap_done", 32'(sawDone), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
